wbu: RTL and testbench

Write-back stage: final stage of the single-issue pipeline, directly downstream of the load/store stage. Latches the 87-bit LSU→WBU bus and commits it one cycle later:
- general-register write
- CSR write
- PC redirect to fetch (jump, trap entry, trap return)
- simulation halt on `ebreak`

Tracks run/halt state and back-pressures the load/store stage once halted.

---
 rtl/wbu.sv | 173 +++++++++++++++++
 tb/tb_wbu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// wbu: write-back stage of the single-issue pipeline.
// Latches one LSU->WBU bus word per cycle and commits it in the following
// cycle: GPR write, CSR write, fetch redirect (jump / trap entry / trap return)
// and halt on ebreak. Once halted the stage stops accepting words until reset.
// Optional feature macro: WBU_RETIRE_CNT_EN adds a 64-bit retired-instruction
// counter driven on retire_cnt_o.
module wbu #(
  parameter int BUS_W = 87
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lsu_valid_i,
  input  logic [BUS_W-1:0] lsu_wbu_bus_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  output logic             ready_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [31:0]      rf_wdata_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [31:0]      csr_wdata_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             commit_o,
  output logic             halt_o
`ifdef WBU_RETIRE_CNT_EN
  ,
  output logic [63:0]      retire_cnt_o
`endif
);

  // Bus field positions
  localparam int CSR_WE_B = 86;
  localparam int RES_HI   = 85;
  localparam int RES_LO   = 54;
  localparam int GR_WE_B  = 53;
  localparam int RD_HI    = 52;
  localparam int RD_LO    = 48;
  localparam int CSRA_HI  = 47;
  localparam int CSRA_LO  = 36;
  localparam int JMP_B    = 35;
  localparam int JT_HI    = 34;
  localparam int JT_LO    = 3;
  localparam int BRK_B    = 2;
  localparam int EXCP_B   = 1;
  localparam int XRET_B   = 0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [BUS_W-1:0]   bus_q, bus_d;
  logic               accept_s;

  // Decoded fields of the latched word
  logic        f_csr_we_s, f_gr_we_s, f_jmp_s, f_brk_s, f_excp_s, f_xret_s;
  logic [31:0] f_result_s, f_jt_s;
  logic [4:0]  f_rd_s;
  logic [11:0] f_csra_s;

  assign f_csr_we_s = bus_q[CSR_WE_B];
  assign f_result_s = bus_q[RES_HI:RES_LO];
  assign f_gr_we_s  = bus_q[GR_WE_B];
  assign f_rd_s     = bus_q[RD_HI:RD_LO];
  assign f_csra_s   = bus_q[CSRA_HI:CSRA_LO];
  assign f_jmp_s    = bus_q[JMP_B];
  assign f_jt_s     = bus_q[JT_HI:JT_LO];
  assign f_brk_s    = bus_q[BRK_B];
  assign f_excp_s   = bus_q[EXCP_B];
  assign f_xret_s   = bus_q[XRET_B];

  assign ready_o  = (state_q == ST_RUN);
  assign accept_s = lsu_valid_i & ready_o;

  // Next-state logic: run/halt FSM plus the one-deep commit register
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    bus_d   = {BUS_W{1'b0}};
    // An idle cycle clears the latched word so idle outputs are all zero
    if (accept_s) begin
      valid_d = 1'b1;
      bus_d   = lsu_wbu_bus_i;
    end else begin
      valid_d = 1'b0;
      bus_d   = {BUS_W{1'b0}};
    end
    case (state_q)
      ST_RUN: begin
        // A trapping ebreak takes the trap instead of halting
        if (accept_s && lsu_wbu_bus_i[BRK_B] && !lsu_wbu_bus_i[EXCP_B]) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // State and commit registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      bus_q   <= {BUS_W{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  // Commit outputs decoded from the latched word; every enable gated by valid_q
  always_comb begin
    rf_we_o       = 1'b0;
    rf_waddr_o    = 5'd0;
    rf_wdata_o    = 32'd0;
    csr_we_o      = 1'b0;
    csr_waddr_o   = 12'd0;
    csr_wdata_o   = 32'd0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'd0;
    commit_o      = 1'b0;

    rf_we_o     = valid_q & f_gr_we_s & (f_rd_s != 5'd0) & ~f_excp_s;
    rf_waddr_o  = f_rd_s;
    rf_wdata_o  = f_result_s;
    csr_we_o    = valid_q & f_csr_we_s & ~f_excp_s;
    csr_waddr_o = f_csra_s;
    csr_wdata_o = f_result_s;
    redirect_o  = valid_q & (f_excp_s | f_xret_s | f_jmp_s);
    commit_o    = valid_q & ~f_excp_s;

    // Trap entry beats trap return beats plain jump
    if (!redirect_o) begin
      redirect_pc_o = 32'd0;
    end else if (f_excp_s) begin
      redirect_pc_o = csr_mtvec_i;
    end else if (f_xret_s) begin
      redirect_pc_o = csr_mepc_i;
    end else begin
      redirect_pc_o = f_jt_s;
    end
  end

  // Halt follows the state register; the committing ebreak term is implied by
  // HALT already and only restates it for the cycle the word is in flight
  assign halt_o = (state_q == ST_HALT) | (valid_q & f_brk_s & ~f_excp_s);

`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retire_cnt_q <= 64'd0;
    end else if (commit_o) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end else begin
      retire_cnt_q <= retire_cnt_q;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: self-checking bench for the write-back stage. Directed cases from
// the stage's behaviour list followed by randomized traffic, all compared
// against a field-level reference model kept here.
module tb_wbu;

  logic        clk;
  logic        rst_i;
  logic        lsu_valid_i;
  logic [86:0] lsu_wbu_bus_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic        ready_o, rf_we_o, csr_we_o, redirect_o, commit_o, halt_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, csr_wdata_o, redirect_pc_o;
  logic [11:0] csr_waddr_o;
`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
`endif

  wbu #(.BUS_W(87)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_wbu_bus_i (lsu_wbu_bus_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .ready_o       (ready_o),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .commit_o      (commit_o),
    .halt_o        (halt_o)
`ifdef WBU_RETIRE_CNT_EN
    ,
    .retire_cnt_o  (retire_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the word being committed this cycle, halt flag, counter
  logic        m_valid;
  logic [86:0] m_word;
  logic        m_halt;
  logic [63:0] m_cnt;
  int          halt_cycles;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [86:0] mk(input logic csr_we, input logic [31:0] result,
                                     input logic gr_we, input logic [4:0] rd,
                                     input logic [11:0] csr_addr, input logic jmp,
                                     input logic [31:0] jt, input logic brk,
                                     input logic excp, input logic xret);
    return {csr_we, result, gr_we, rd, csr_addr, jmp, jt, brk, excp, xret};
  endfunction

  // Compare every output with what the model says the stage should show now
  task automatic check_outputs();
    logic        csr_we, gr_we, jmp, excp, xret, redir;
    logic [31:0] result, jt, pc;
    logic [4:0]  rd;
    logic [11:0] csra;
    {csr_we, result, gr_we, rd, csra, jmp, jt} = m_word[86:3];
    excp  = m_word[1];
    xret  = m_word[0];
    redir = m_valid && (excp || xret || jmp);
    if (!redir)     pc = 32'd0;
    else if (excp)  pc = csr_mtvec_i;
    else if (xret)  pc = csr_mepc_i;
    else            pc = jt;
    check_eq("ready", 64'(ready_o), 64'(!m_halt));
    check_eq("halt", 64'(halt_o), 64'(m_halt));
    check_eq("rf_we", 64'(rf_we_o), 64'(m_valid && gr_we && rd != 5'd0 && !excp));
    check_eq("csr_we", 64'(csr_we_o), 64'(m_valid && csr_we && !excp));
    check_eq("redirect", 64'(redirect_o), 64'(redir));
    check_eq("redirect_pc", 64'(redirect_pc_o), 64'(pc));
    check_eq("commit", 64'(commit_o), 64'(m_valid && !excp));
    if (m_valid) begin
      check_eq("rf_waddr", 64'(rf_waddr_o), 64'(rd));
      check_eq("rf_wdata", 64'(rf_wdata_o), 64'(result));
      check_eq("csr_waddr", 64'(csr_waddr_o), 64'(csra));
      check_eq("csr_wdata", 64'(csr_wdata_o), 64'(result));
    end
`ifdef WBU_RETIRE_CNT_EN
    check_eq("retire_cnt", retire_cnt_o, m_cnt);
`endif
  endtask

  // Everything must read zero except ready while reset holds
  task automatic check_reset_state();
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_halt", 64'(halt_o), 64'd0);
    check_eq("rst_rf_we", 64'(rf_we_o), 64'd0);
    check_eq("rst_rf_waddr", 64'(rf_waddr_o), 64'd0);
    check_eq("rst_rf_wdata", 64'(rf_wdata_o), 64'd0);
    check_eq("rst_csr_we", 64'(csr_we_o), 64'd0);
    check_eq("rst_csr_waddr", 64'(csr_waddr_o), 64'd0);
    check_eq("rst_csr_wdata", 64'(csr_wdata_o), 64'd0);
    check_eq("rst_redirect", 64'(redirect_o), 64'd0);
    check_eq("rst_redirect_pc", 64'(redirect_pc_o), 64'd0);
    check_eq("rst_commit", 64'(commit_o), 64'd0);
`ifdef WBU_RETIRE_CNT_EN
    check_eq("rst_retire_cnt", retire_cnt_o, 64'd0);
`endif
  endtask

  // One clock: present a word, advance the model at the edge, then check
  task automatic step(input logic v, input logic [86:0] w);
    lsu_valid_i   = v;
    lsu_wbu_bus_i = w;
    @(posedge clk);
    if (m_valid && !m_word[1]) m_cnt = m_cnt + 64'd1;
    if (v && !m_halt) begin
      m_valid = 1'b1;
      m_word  = w;
      if (w[2] && !w[1]) m_halt = 1'b1;
    end else begin
      m_valid = 1'b0;
      m_word  = 87'd0;
    end
    #1;
    lsu_valid_i = 1'b0;
    check_outputs();
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release after an edge
  task automatic mid_reset();
    #3;
    rst_i       = 1'b1;
    lsu_valid_i = 1'b0;
    #1;
    check_reset_state();
    m_valid = 1'b0;
    m_word  = 87'd0;
    m_halt  = 1'b0;
    m_cnt   = 64'd0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_state();
  endtask

  initial begin
    logic [95:0] r;
    logic [86:0] w;
    rst_i         = 1'b1;
    lsu_valid_i   = 1'b0;
    lsu_wbu_bus_i = 87'd0;
    csr_mtvec_i   = 32'h8000_1000;
    csr_mepc_i    = 32'h8000_0200;
    m_valid = 1'b0;
    m_word  = 87'd0;
    m_halt  = 1'b0;
    m_cnt   = 64'd0;
    halt_cycles = 0;
    #12;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // GPR write, then an idle cycle
    step(1'b1, mk(1'b0, 32'hDEAD_BEEF, 1'b1, 5'd5, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
    check_eq("gpr_we", 64'(rf_we_o), 64'd1);
    check_eq("gpr_addr", 64'(rf_waddr_o), 64'd5);
    check_eq("gpr_data", 64'(rf_wdata_o), 64'hDEAD_BEEF);
    step(1'b0, 87'd0);
    check_eq("idle_we", 64'(rf_we_o), 64'd0);

    // x0 write suppressed but still retires; CSR write
    step(1'b1, mk(1'b0, 32'h1234_5678, 1'b1, 5'd0, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
    check_eq("x0_we", 64'(rf_we_o), 64'd0);
    check_eq("x0_commit", 64'(commit_o), 64'd1);
    step(1'b1, mk(1'b1, 32'h8000_0100, 1'b0, 5'd0, 12'h305, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
    check_eq("csr_we_d", 64'(csr_we_o), 64'd1);
    check_eq("csr_addr_d", 64'(csr_waddr_o), 64'h305);
    check_eq("csr_data_d", 64'(csr_wdata_o), 64'h8000_0100);

    // Redirects: jump, trap (excp wins over jmp), trap return, back-to-back
    step(1'b1, mk(1'b0, 32'd0, 1'b0, 5'd0, 12'd0, 1'b1, 32'h8000_0040, 1'b0, 1'b0, 1'b0));
    check_eq("jmp_pc", 64'(redirect_pc_o), 64'h8000_0040);
    step(1'b0, 87'd0);
    check_eq("jmp_pulse_end", 64'(redirect_o), 64'd0);
    step(1'b1, mk(1'b0, 32'd1, 1'b1, 5'd3, 12'd0, 1'b1, 32'h8000_0040, 1'b0, 1'b1, 1'b0));
    check_eq("excp_pc", 64'(redirect_pc_o), 64'h8000_1000);
    check_eq("excp_commit", 64'(commit_o), 64'd0);
    check_eq("excp_rf_we", 64'(rf_we_o), 64'd0);
    step(1'b1, mk(1'b0, 32'd0, 1'b0, 5'd0, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1));
    check_eq("xret_pc", 64'(redirect_pc_o), 64'h8000_0200);
    step(1'b1, mk(1'b0, 32'd0, 1'b0, 5'd0, 12'd0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0));
    check_eq("b2b_redir_1", 64'(redirect_o), 64'd1);
    // brk together with excp traps instead of halting
    step(1'b1, mk(1'b0, 32'd0, 1'b0, 5'd0, 12'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0));
    check_eq("b2b_redir_2", 64'(redirect_o), 64'd1);
    check_eq("brk_excp_nohalt", 64'(halt_o), 64'd0);

    // ebreak halts; three later words are ignored
    step(1'b1, mk(1'b0, 32'hAAAA_5555, 1'b1, 5'd10, 12'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0));
    check_eq("brk_rf_we", 64'(rf_we_o), 64'd1);
    check_eq("brk_halt", 64'(halt_o), 64'd1);
    check_eq("brk_ready", 64'(ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(1'b0, 32'h1, 1'b1, 5'd7, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      check_eq("halted_commit", 64'(commit_o), 64'd0);
    end
    mid_reset();

    // Reset while committing a halting word, then normal operation resumes
    step(1'b1, mk(1'b0, 32'h0000_0042, 1'b1, 5'd11, 12'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0));
    mid_reset();
    step(1'b1, mk(1'b0, 32'h0000_0099, 1'b1, 5'd12, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
    check_eq("post_rst_we", 64'(rf_we_o), 64'd1);

`ifdef WBU_RETIRE_CNT_EN
    mid_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, mk(1'b0, 32'(i), 1'b1, 5'd1, 12'd0, 1'b0, 32'd0, 1'b0, 1'(i == 4), 1'b0));
    step(1'b0, 87'd0);
    check_eq("cnt_nine", retire_cnt_o, 64'd9);
    force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1'b1, mk(1'b0, 32'd0, 1'b0, 5'd0, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 87'd0);
    check_eq("cnt_wrap", retire_cnt_o, 64'd0);
`endif

    // Randomized traffic with occasional halts, recovered by reset
    for (int i = 0; i < 600; i++) begin
      if (m_halt) halt_cycles++;
      else        halt_cycles = 0;
      if (halt_cycles > 4) begin
        mid_reset();
        halt_cycles = 0;
      end
      r = {$urandom(), $urandom(), $urandom()};
      w = r[86:0];
      w[2] = ($urandom_range(0, 39) == 0);
      w[1] = ($urandom_range(0, 5) == 0);
      w[0] = ($urandom_range(0, 5) == 0);
      csr_mtvec_i = $urandom();
      csr_mepc_i  = $urandom();
      step(1'($urandom_range(0, 9) < 7), w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
